// File: rtl/pipeicache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package pipeicache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int BLOCK_BYTES = 32;
  localparam int BLOCK_W     = 256;
  localparam int WORD_SEL_W  = 3;

  // Line index field, right-justified in 32 bits; callers size-cast it.
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int index_w);
    return (a >> 5) & ((32'd1 << index_w) - 32'd1);
  endfunction

  // Tag field, right-justified in 32 bits; callers size-cast it.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int index_w);
    return a >> (5 + index_w);
  endfunction

  // Word-within-block select; the byte offset bits are dropped.
  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] a);
    return WORD_SEL_W'(a >> 2);
  endfunction

  // Block-aligned address used for refill requests.
  function automatic logic [31:0] block_addr(input logic [31:0] a);
    return a & ~32'(BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/pipeicache_array.sv
// Valid/tag/data storage: asynchronous read port, synchronous write port,
// flush clears every valid bit and wins over a same-cycle write.
module pipeicache_array
  import pipeicache_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // Next valid vector: flush clears all lines, otherwise a refill marks its line.
  always_comb begin
    valid_d = valid_q;
    if (flush)      valid_d = '0;
    else if (wr_en) valid_d[wr_index] = 1'b1;
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag/data payload; no reset since valid gates every use.
  always_ff @(posedge clock) begin
    if (wr_en && !flush) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/pipeicache_ctrl.sv
// Direct-mapped I-cache controller: combinational hit path, IDLE/FETCH/WAIT
// refill sequencer owning the instruction-memory en/addr.
// Optional ICACHE_PERF_EN adds hit_count/miss_count outputs.
module pipeicache_ctrl
  import pipeicache_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = 32 - 5 - INDEX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [31:0]        cpu_addr,
  output logic [31:0]        cpu_inst,
  output logic               cpu_stall,
  input  logic               flush,
  output logic               mem_en,
  output logic [31:0]        mem_addr,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  state_t state_q, state_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [INDEX_W-1:0]            rd_index;
  logic [TAG_W-1:0]              cpu_tag, rd_tag;
  logic                          rd_valid, hit, wr_en;
  logic [BLOCK_W-1:0]            rd_data;
  logic [BLOCK_W/32-1:0][31:0]   line_words;

  assign rd_index   = INDEX_W'(addr_index(cpu_addr, INDEX_W));
  assign cpu_tag    = TAG_W'(addr_tag(cpu_addr, INDEX_W));
  assign hit        = cpu_req & rd_valid & (rd_tag == cpu_tag);
  assign line_words = rd_data;
  assign cpu_inst   = line_words[addr_word(cpu_addr)];
  assign cpu_stall  = (state_q == IDLE) ? (cpu_req & ~hit) : 1'b1;

  // A flush landing on the completion cycle suppresses the line write.
  assign wr_en = (state_q == WAIT) & mem_ready & ~flush;

  pipeicache_array #(
    .LINES  (LINES),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .rd_index(rd_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(INDEX_W'(addr_index(mem_addr_q, INDEX_W))),
    .wr_tag  (TAG_W'(addr_tag(mem_addr_q, INDEX_W))),
    .wr_data (mem_data)
  );

  // Next-state and next memory request; mem_addr doubles as the latched miss address.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (cpu_req && !hit) begin
        state_d    = FETCH;
        mem_addr_d = block_addr(cpu_addr);
      end
      FETCH:   state_d = WAIT;          // memory output is stale this cycle
      WAIT:    if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) state_d = IDLE;
    mem_en_d = (state_d != IDLE);
    if (state_d == IDLE) mem_addr_d = '0;
  end

  // FSM state and registered memory-interface outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Counters wrap naturally and ignore flush.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && hit)        hit_count_d  = hit_count_q + 32'd1;
    if (state_q == IDLE && cpu_stall)  miss_count_d = miss_count_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_pipeicache_ctrl.sv
// Scoreboard bench for pipeicache_ctrl: the driver queues expected instructions
// and memory requests, a forked monitor checks them as the DUT presents them.
module tb_pipeicache_ctrl;

  logic         clock = 1'b0;
  logic         reset, cpu_req, flush, mem_ready;
  logic [31:0]  cpu_addr, cpu_inst, mem_addr;
  logic         cpu_stall, mem_en;
  logic [255:0] mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count, miss_count;
`endif

  pipeicache_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_inst (cpu_inst),
    .cpu_stall(cpu_stall),
    .flush    (flush),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_data (mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Memory model: ready once mem_en has been high for more than 'extra'
  // registered cycles, i.e. first WAIT cycle when extra=0.
  int extra = 0;
  int mcnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] blk, input int k);
    if (blk == 32'h0 && k == 0) return 32'h2001_0005;
    return (blk | 32'(k << 2)) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clock) mcnt <= mem_en ? mcnt + 1 : 0;

  always_comb begin
    mem_ready = !mem_en || (mcnt > extra);
    mem_data  = '0;
    if (mem_en && mcnt > extra)
      for (int k = 0; k < 8; k++) mem_data[32*k +: 32] = mem_word(mem_addr, k);
  end

  typedef struct {
    logic [31:0] addr;
    int          len;
  } mreq_t;

  logic [31:0] inst_q[$];
  mreq_t       mem_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / did not occur at %0t", name, $time);
  endtask

  task automatic expect_mem(input logic [31:0] a, input int len);
    mreq_t m;
    m.addr = a;
    m.len  = len;
    mem_q.push_back(m);
  endtask

  // Monitor state (only touched by the forked monitor process).
  bit          in_ep = 0;
  int          ep_len = 0, ep_exp_len = 0;
  logic [31:0] ep_addr = '0;

  task automatic monitor_step();
    logic [31:0] e;
    mreq_t m;
    if (cpu_req && !cpu_stall) begin
      if (inst_q.size() == 0) fail("inst_unexpected");
      else begin
        e = inst_q.pop_front();
        chk("cpu_inst", cpu_inst, e);
      end
    end
    if (mem_en) begin
      if (!in_ep) begin
        in_ep  = 1;
        ep_len = 1;
        ep_addr = mem_addr;
        if (mem_q.size() == 0) begin
          fail("mem_req_unexpected");
          ep_exp_len = 0;
        end else begin
          m = mem_q.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          ep_exp_len = m.len;
        end
      end else begin
        ep_len++;
        chk("mem_addr_hold", mem_addr, ep_addr);
      end
    end else begin
      chk("mem_addr_idle", mem_addr, 32'h0);
      if (in_ep) begin
        in_ep = 0;
        chk("mem_en_len", 32'(ep_len), 32'(ep_ext_len_fix(ep_exp_len)));
      end
    end
  endtask

  function automatic int ep_ext_len_fix(input int v);
    return v;
  endfunction

  // Request one fetch, hold it until stall drops, and check the stall length.
  // flush/reset are pulsed in the cycle numbered flush_at/reset_at (0 = request cycle).
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst, input int exp_stall,
                       input int flush_at, input int reset_at);
    int n = 0;
    int cyc = 0;
    inst_q.push_back(exp_inst);
    cpu_req  = 1'b1;
    cpu_addr = a;
    while (1) begin
      flush = (cyc == flush_at);
      reset = (cyc == reset_at);
      @(negedge clock);
      if (cyc == reset_at) begin
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'h1);
`ifdef ICACHE_PERF_EN
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
`endif
      end
      if (!cpu_stall) break;
      n++;
      cyc++;
      if (cyc > 60) begin
        fail("fetch_timeout");
        break;
      end
      @(posedge clock);
      #1;
    end
    flush = 1'b0;
    reset = 1'b0;
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    if (exp_stall == 0) chk("mem_en_on_hit", {31'b0, mem_en}, 32'h0);
    @(posedge clock);
    #1;
  endtask

  // Hand-computed words 1..7 of block 0x0.
  logic [31:0] blk0_words [7] = '{32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C, 32'hA5A5_0010,
                                  32'hA5A5_0014, 32'hA5A5_0018, 32'hA5A5_001C};

  initial begin
    fork
      forever begin
        @(negedge clock);
        monitor_step();
      end
    join_none

    reset = 1'b1; cpu_req = 1'b1; cpu_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset_stall_eq_req", {31'b0, cpu_stall}, 32'h1);
    chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
`ifdef ICACHE_PERF_EN
    chk("reset_hit_count", hit_count, 32'h0);
    chk("reset_miss_count", miss_count, 32'h0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    chk("idle_noreq_stall", {31'b0, cpu_stall}, 32'h0);
    @(posedge clock);
    #1;

    // Test 1: cold miss on block 0
    expect_mem(32'h0, 2);
    fetch(32'h0, 32'h2001_0005, 3, -1, -1);

    // Test 2: rest of the block hits back to back
    for (int k = 0; k < 7; k++) fetch(32'(4 * (k + 1)), blk0_words[k], 0, -1, -1);
    cpu_req = 1'b0;
    @(negedge clock);
`ifdef ICACHE_PERF_EN
    // The cycle that completes the test-1 refill is itself an IDLE hit: 1 + 7.
    chk("perf_hit_count", hit_count, 32'd8);
    chk("perf_miss_count", miss_count, 32'd1);
`endif
    @(posedge clock);
    #1;

    // Test 3: conflicting tag on index 0 evicts, then block 0 misses again
    expect_mem(32'h100, 2);
    fetch(32'h100, 32'hA5A5_0100, 3, -1, -1);
    expect_mem(32'h0, 2);
    fetch(32'h0, 32'h2001_0005, 3, -1, -1);

    // Test 4: slow memory, ready on the 4th WAIT cycle
    extra = 3;
    expect_mem(32'h40, 5);
    fetch(32'h48, 32'hA5A5_0048, 6, -1, -1);
    extra = 0;

    // Test 5: flush on the WAIT completion cycle abandons the fill, IF re-misses
    expect_mem(32'h60, 2);
    expect_mem(32'h60, 2);
    fetch(32'h64, 32'hA5A5_0064, 6, 2, -1);

    // Test 6: reset mid-WAIT, then refill restarts; earlier hit line now misses
    extra = 3;
    expect_mem(32'h80, 2);
    expect_mem(32'h80, 5);
    fetch(32'h84, 32'hA5A5_0084, 10, -1, 3);
    extra = 0;
    expect_mem(32'h0, 2);
    fetch(32'h0, 32'h2001_0005, 3, -1, -1);

    cpu_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("inst_q_drained", 32'(inst_q.size()), 32'h0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
